mips_run_ctrl: RTL and testbench

Run controller that sequences the MIPS core for a complete program run. Holds the core in reset and streams a program into instruction memory over a valid/ready port. It then releases the core and counts executed cycles. The run stops on a halt instruction or a cycle limit, and the controller re-freezes the core so data memory and the register file can be inspected. It sits between the host/testbench side and the `mips` top level, driving its reset and the instruction-memory write port.

---
 rtl/mips_run_pkg.sv | 16 +
 rtl/sat_counter.sv | 23 ++
 rtl/mips_run_ctrl.sv | 131 +++++++++++++
 tb/tb_mips_run_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_run_pkg.sv
// Shared types and default parameters for the MIPS run controller.
package mips_run_pkg;

  localparam int unsigned IMEM_AW_DEF = 8;
  localparam int unsigned CYC_W_DEF   = 16;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFC00_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_RUN,
    ST_DONE
  } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear has priority; increment stops once every bit is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Sequences a MIPS core through program load, release, counted run and freeze.
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int unsigned IMEM_AW   = IMEM_AW_DEF,
  parameter int unsigned CYC_W     = CYC_W_DEF,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [CYC_W-1:0]   cycle_limit,
  input  logic               ld_valid,
  input  logic [31:0]        ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_reset,
  input  logic [31:0]        cpu_instr,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CYC_W-1:0]   cycles
);

  localparam logic [IMEM_AW-1:0] PTR_LAST = '1;

  run_state_t         state;
  logic [IMEM_AW-1:0] wptr;
  logic [CYC_W-1:0]   limit_q;
  logic [CYC_W:0]     cyc_next;
  logic               accept;
  logic               abort_hit;
  logic               start_ok;
  logic               halt_seen;
  logic               limit_hit;

  // Load port: a word is written in the same cycle it is accepted.
  assign accept     = ld_valid & ld_ready;
  assign imem_we    = accept;
  assign imem_addr  = wptr;
  assign imem_wdata = ld_data;

  // Abort only matters outside IDLE and beats every other transition.
  assign abort_hit = abort & (state != ST_IDLE);
  assign start_ok  = start & ((state == ST_IDLE) | (state == ST_DONE)) & ~abort_hit;

  // Run-end detection; the extra bit keeps cycles+1 from wrapping.
  assign halt_seen = (cpu_instr == HALT_WORD);
  assign cyc_next  = {1'b0, cycles} + (CYC_W + 1)'(1);
  assign limit_hit = (limit_q != '0) && (cyc_next == {1'b0, limit_q});

  // RUN-cycle counter; the abort cycle is still a RUN cycle and is counted.
  sat_counter #(
    .W(CYC_W)
  ) u_cycles (
    .clk  (clk),
    .reset(reset),
    .clr  (start_ok),
    .en   (state == ST_RUN),
    .count(cycles)
  );

  // Controller FSM with registered status and core reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wptr      <= '0;
      limit_q   <= '0;
      ld_ready  <= 1'b0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else if (abort_hit) begin
      state     <= ST_IDLE;
      ld_ready  <= 1'b0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state     <= ST_LOAD;
            wptr      <= '0;
            limit_q   <= cycle_limit;
            ld_ready  <= 1'b1;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            wptr <= IMEM_AW'(wptr + IMEM_AW'(1));
            if (ld_last || (wptr == PTR_LAST)) begin
              state    <= ST_RELEASE;
              ld_ready <= 1'b0;
            end
          end
        end
        ST_RELEASE: begin
          state     <= ST_RUN;
          cpu_reset <= 1'b0;
        end
        ST_RUN: begin
          if (halt_seen || limit_hit) begin
            state     <= ST_DONE;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            timeout   <= ~halt_seen;
          end
        end
        default: begin
          state     <= ST_IDLE;
          ld_ready  <= 1'b0;
          cpu_reset <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed plus randomized bench for mips_run_ctrl with a run-outcome model.
module tb_mips_run_ctrl;

  localparam int unsigned IMEM_AW = 8;
  localparam int unsigned CYC_W   = 16;
  localparam int unsigned DEPTH   = 256;
  localparam logic [31:0] HALT    = 32'hFC00_0000;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               abort;
  logic [CYC_W-1:0]   cycle_limit;
  logic               ld_valid;
  logic [31:0]        ld_data;
  logic               ld_last;
  logic               ld_ready;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic               cpu_reset;
  logic [31:0]        cpu_instr;
  logic               busy;
  logic               done;
  logic               timeout;
  logic [CYC_W-1:0]   cycles;

  int total = 0;
  int bad   = 0;
  int nwr   = 0;
  logic [31:0] mem  [0:DEPTH-1];
  logic [31:0] prog [0:259];

  mips_run_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .cycle_limit(cycle_limit),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .cpu_instr  (cpu_instr),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in capturing every write the controller makes.
  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_addr] = imem_wdata;
      nwr = nwr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] nonhalt();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_cpu_reset"}, cpu_reset, 1);
    chk({pfx, "_ld_ready"}, ld_ready, 0);
    chk({pfx, "_imem_we"}, imem_we, 0);
    chk({pfx, "_imem_addr"}, imem_addr, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_timeout"}, timeout, 0);
    chk({pfx, "_cycles"}, cycles, 0);
  endtask

  // One complete program run. mode: 0 valid always, 1 every other cycle, 2 random.
  // halt_at/abort_at/start_at are 1-based RUN cycles, 0 = never.
  task automatic run_prog(input int n, input int mode, input int halt_at, input int limit,
                          input int abort_at, input int start_at);
    int  nstore, nwr0, end_k, stop_k, i, c, errs;
    bit  v, halt_first, aborted;
    nstore = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    for (int j = 0; j < n; j++) prog[j] = $urandom;
    // Outcome model: earliest of halt cycle and limit, halt winning ties.
    halt_first = (halt_at != 0) && (limit == 0 || halt_at <= limit);
    end_k      = halt_first ? halt_at : ((limit != 0) ? limit : 1000);
    aborted    = (abort_at != 0) && (abort_at <= end_k);
    stop_k     = aborted ? abort_at : end_k;
    nwr0 = nwr;

    cycle_limit = CYC_W'(limit);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycle_limit = CYC_W'($urandom);
    chk("load_ld_ready", ld_ready, 1);
    chk("load_busy", busy, 1);
    chk("load_cpu_reset", cpu_reset, 1);
    chk("load_done", done, 0);
    chk("load_timeout", timeout, 0);
    chk("load_cycles", cycles, 0);

    i = 0;
    c = 0;
    while (i < nstore && c < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (c % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      ld_valid = v;
      ld_data  = prog[i];
      ld_last  = (i == n - 1);
      #1;
      chk("imem_we", imem_we, 32'(v));
      chk("imem_addr", imem_addr, i);
      if (v) begin
        chk("imem_wdata", imem_wdata, prog[i]);
        i++;
      end
      c++;
      @(posedge clk); #1;
    end
    chk("load_budget", i, nstore);

    // RELEASE: surplus words stay offered but must not be taken.
    ld_valid = (n > nstore);
    ld_data  = (n > nstore) ? prog[nstore] : 32'h0;
    ld_last  = 1'b0;
    #1;
    chk("rel_ld_ready", ld_ready, 0);
    chk("rel_imem_we", imem_we, 0);
    chk("rel_cpu_reset", cpu_reset, 1);
    chk("rel_busy", busy, 1);
    @(posedge clk); #1;
    ld_valid = 1'b0;

    for (int k = 1; k <= stop_k; k++) begin
      cpu_instr = (k == halt_at) ? HALT : nonhalt();
      abort = (k == abort_at);
      start = (k == start_at);
      #1;
      chk("run_cycles", cycles, k - 1);
      chk("run_cpu_reset", cpu_reset, 0);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
    end
    cpu_instr = nonhalt();

    if (aborted) begin
      chk("abort_busy", busy, 0);
      chk("abort_cpu_reset", cpu_reset, 1);
      chk("abort_done", done, 0);
      chk("abort_timeout", timeout, 0);
      chk("abort_ld_ready", ld_ready, 0);
      chk("abort_cycles", cycles, abort_at);
    end else begin
      chk("end_done", done, 1);
      chk("end_timeout", timeout, 32'(!halt_first));
      chk("end_cycles", cycles, end_k);
      chk("end_cpu_reset", cpu_reset, 1);
      chk("end_busy", busy, 0);
      @(posedge clk); #1;
      chk("hold_cycles", cycles, end_k);
      chk("hold_done", done, 1);
    end

    chk("write_count", nwr - nwr0, nstore);
    errs = 0;
    for (int j = 0; j < nstore; j++) if (mem[j] !== prog[j]) errs++;
    chk("mem_contents_bad_words", errs, 0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    cycle_limit = '0;
    ld_valid    = 1'b0;
    ld_data     = '0;
    ld_last     = 1'b0;
    cpu_instr   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset = 1'b0;
    @(posedge clk); #1;

    run_prog(4, 0, 3, 0, 0, 0);      // basic 4-word load and short run
    run_prog(12, 0, 10, 0, 0, 0);    // halt on 10th fetch, unlimited
    run_prog(6, 0, 0, 5, 0, 0);      // limit 5, no halt
    run_prog(6, 0, 5, 5, 0, 0);      // halt and limit coincide
    run_prog(8, 1, 4, 0, 0, 0);      // valid every other cycle
    run_prog(260, 0, 2, 0, 0, 0);    // overflow past memory end
    run_prog(5, 0, 0, 0, 3, 2);      // start ignored at 2, abort at 3

    // Asynchronous reset in the middle of a load.
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'h1234_5678;
    ld_last  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    ld_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_prog(3, 2, 6, 9, 0, 0);      // from IDLE after reset
    run_prog(3, 0, 2, 0, 0, 0);      // fresh start from DONE

    for (int r = 0; r < 8; r++) begin
      int n, md, lim, h;
      n   = $urandom_range(1, 20);
      md  = $urandom_range(0, 2);
      lim = $urandom_range(0, 12);
      h   = $urandom_range(0, 12);
      if (lim == 0 && h == 0) h = 7;
      run_prog(n, md, h, lim, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
